ram_sync_clr: RTL and testbench



---
 rtl/ram_sync_clr_if.sv | 25 ++
 rtl/ram_sync_clr.sv | 79 +++++++
 tb/tb_ram_sync_clr.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ram_sync_clr_if.sv
// Bus bundle for ram_sync_clr: write port, read port and status.
// The master drives the access pins, the RAM drives read data and status.
interface ram_sync_clr_if #(
    parameter int n = 8,
    parameter int a = 5
);
    logic         WE;
    logic [a-1:0] WAddr;
    logic [n-1:0] D;
    logic         RE;
    logic [a-1:0] RAddr;
    logic [n-1:0] Q;
    logic         QValid;
    logic         Busy;

    modport master (
        output WE, WAddr, D, RE, RAddr,
        input  Q, QValid, Busy
    );

    modport slave (
        input  WE, WAddr, D, RE, RAddr,
        output Q, QValid, Busy
    );
endinterface

// File: rtl/ram_sync_clr.sv
// Synchronous 2^a x n RAM with a registered read port and a
// zero-fill sweep that runs after every reset release.
module ram_sync_clr #(
    parameter int n        = 8,
    parameter int a        = 5,
    parameter int RDW_MODE = 0
) (
    input logic           clk,
    input logic           clear,
    ram_sync_clr_if.slave bus
);
    localparam int DEPTH = 1 << a;

    localparam logic SWEEP = 1'b0;
    localparam logic READY = 1'b1;

    // One bit wider than the address so the sweep can never wrap.
    localparam logic [a:0] LAST = {1'b0, {a{1'b1}}};

    logic         state;
    logic [a:0]   cnt;
    logic [n-1:0] mem [DEPTH];
    logic [n-1:0] q;
    logic         qvalid;
    logic         rd_hit;
    logic         wr_go;
    logic         rd_go;

    assign wr_go  = (state == READY) && bus.WE;
    assign rd_go  = (state == READY) && bus.RE;
    assign rd_hit = wr_go && (bus.WAddr == bus.RAddr);

    assign bus.Busy   = (state == SWEEP);
    assign bus.Q      = q;
    assign bus.QValid = qvalid;

    // Storage has no reset; it is only frozen while clear is held.
    always_ff @(posedge clk) begin
        if (clear) begin
            if (state == SWEEP) begin
                mem[cnt[a-1:0]] <= '0;
            end else if (wr_go) begin
                mem[bus.WAddr] <= bus.D;
            end
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state  <= SWEEP;
            cnt    <= '0;
            q      <= '0;
            qvalid <= 1'b0;
        end else begin
            case (state)
                SWEEP: begin
                    qvalid <= 1'b0;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= READY;
                    end
                end
                READY: begin
                    qvalid <= rd_go;
                    if (rd_go) begin
                        if (RDW_MODE == 1 && rd_hit) begin
                            q <= bus.D;
                        end else begin
                            q <= mem[bus.RAddr];
                        end
                    end
                end
                default: begin
                    state <= SWEEP;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_sync_clr.sv
// Bench for ram_sync_clr: read-first and write-through instances
// driven in lockstep and checked against a queue of expected reads.
module tb_ram_sync_clr;
    localparam int N     = 8;
    localparam int A     = 5;
    localparam int DEPTH = 1 << A;

    logic clk   = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    ram_sync_clr_if #(.n(N), .a(A)) b0 ();
    ram_sync_clr_if #(.n(N), .a(A)) b1 ();

    assign b1.WE    = b0.WE;
    assign b1.WAddr = b0.WAddr;
    assign b1.D     = b0.D;
    assign b1.RE    = b0.RE;
    assign b1.RAddr = b0.RAddr;

    ram_sync_clr #(.n(N), .a(A), .RDW_MODE(0)) dut0 (
        .clk(clk), .clear(clear), .bus(b0)
    );
    ram_sync_clr #(.n(N), .a(A), .RDW_MODE(1)) dut1 (
        .clk(clk), .clear(clear), .bus(b1)
    );

    logic [N-1:0] qo [2];
    logic         qv [2];
    logic         by [2];
    assign qo[0] = b0.Q;
    assign qo[1] = b1.Q;
    assign qv[0] = b0.QValid;
    assign qv[1] = b1.QValid;
    assign by[0] = b0.Busy;
    assign by[1] = b1.Busy;

    logic [N-1:0] model [DEPTH];
    logic [N-1:0] sb0 [$];
    logic [N-1:0] sb1 [$];
    int total = 0;
    int bad   = 0;

    task automatic step(input string tag,
                        input logic we, input logic [A-1:0] wa,
                        input logic [N-1:0] d,
                        input logic re, input logic [A-1:0] ra);
        logic [N-1:0] e [2];
        e[0] = '0;
        e[1] = '0;
        b0.WE    = we;
        b0.WAddr = we ? wa : 'x;
        b0.D     = we ? d : 'x;
        b0.RE    = re;
        b0.RAddr = re ? ra : 'x;
        if (re) begin
            sb0.push_back(model[ra]);
            sb1.push_back((we && wa == ra) ? d : model[ra]);
        end
        if (we) model[wa] = d;
        @(posedge clk);
        #1;
        if (re) begin
            e[0] = sb0.pop_front();
            e[1] = sb1.pop_front();
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (qv[k] !== re) begin
                bad++;
                $display("FAIL %s qvalid dut%0d got=%b exp=%b",
                         tag, k, qv[k], re);
            end
            if (re) begin
                total++;
                if (qo[k] !== e[k]) begin
                    bad++;
                    $display("FAIL %s q dut%0d addr=%0d got=%h exp=%h",
                             tag, k, ra, qo[k], e[k]);
                end
            end
        end
    endtask

    task automatic sweep_check(input string tag, input bit poke);
        logic bexp;
        for (int i = 1; i <= DEPTH; i++) begin
            b0.WE    = poke;
            b0.WAddr = 5'd5;
            b0.D     = 8'hAA;
            b0.RE    = poke;
            b0.RAddr = 5'd5;
            @(posedge clk);
            #1;
            bexp = (i < DEPTH);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (by[k] !== bexp || qv[k] !== 1'b0 || qo[k] !== '0) begin
                    bad++;
                    $display("FAIL %s edge%0d dut%0d got=%b/%b/%h exp=%b/0/00",
                             tag, i, k, by[k], qv[k], qo[k], bexp);
                end
            end
        end
        b0.WE = 1'b0;
        b0.RE = 1'b0;
        for (int j = 0; j < DEPTH; j++) model[j] = '0;
    endtask

    task automatic read_all_zero(input string tag);
        for (int j = 0; j < DEPTH; j++) step(tag, 0, '0, '0, 1, A'(j));
    endtask

    task automatic test_reset();
        clear = 1'b0;
        b0.WE = 1'b0;
        b0.RE = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (by[k] !== 1'b1 || qv[k] !== 1'b0 || qo[k] !== '0) begin
                bad++;
                $display("FAIL reset dut%0d got=%b/%b/%h exp=1/0/00",
                         k, by[k], qv[k], qo[k]);
            end
        end
        clear = 1'b1;
        sweep_check("sweep", 1'b0);
        read_all_zero("sweep_zero");
    endtask

    task automatic test_sweep_ignore();
        clear = 1'b0;
        #10;
        clear = 1'b1;
        sweep_check("ignore", 1'b1);
        step("ignore_rd5", 0, '0, '0, 1, 5'd5);
    endtask

    task automatic test_write_read();
        for (int j = 0; j < 5; j++) step("wr", 1, A'(j), N'(j), 0, '0);
        for (int j = 0; j < 5; j++) step("rd", 0, '0, '0, 1, A'(j));
        step("idle", 0, '0, '0, 0, '0);
        step("wr9", 1, 5'd9, 8'h5A, 0, '0);
        step("raw9", 0, '0, '0, 1, 5'd9);
    endtask

    task automatic test_collision();
        step("col_pre", 1, 5'd7, 8'h11, 0, '0);
        step("col", 1, 5'd7, 8'h22, 1, 5'd7);
        step("col_post", 0, '0, '0, 1, 5'd7);
    endtask

    task automatic test_boundary();
        step("b_wr31", 1, 5'd31, 8'hFF, 0, '0);
        step("b_rd31", 0, '0, '0, 1, 5'd31);
        step("b_rd0", 0, '0, '0, 1, 5'd0);
    endtask

    task automatic test_mid_reset();
        step("m_rd1", 0, '0, '0, 1, 5'd1);
        step("m_rd2", 0, '0, '0, 1, 5'd2);
        b0.RE    = 1'b1;
        b0.RAddr = 5'd3;
        #2;
        clear = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (by[k] !== 1'b1 || qv[k] !== 1'b0 || qo[k] !== '0) begin
                bad++;
                $display("FAIL midreset dut%0d got=%b/%b/%h exp=1/0/00",
                         k, by[k], qv[k], qo[k]);
            end
        end
        #2;
        clear = 1'b1;
        sweep_check("m_sweep", 1'b1);
        read_all_zero("m_zero");
    endtask

    initial begin
        test_reset();
        test_sweep_ignore();
        test_write_read();
        test_collision();
        test_boundary();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
